// File: rtl/led_row_scan_ctrl_pkg.sv
// Shared definitions for the 8x8 LED row scanner: array geometry and scan FSM encoding.
package led_row_scan_ctrl_pkg;

  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned COL_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BLK  = 2'd1,
    SHOW = 2'd2
  } scan_state_t;

endpackage

// File: rtl/led_frame_dbuf.sv
// Double-buffered 8x8 frame store: writes always land in the back bank, reads come from the front bank.
module led_frame_dbuf
  import led_row_scan_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_data,
  input  logic             swap,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COL_W-1:0] rd_data_c
);

  logic [COL_W-1:0] bank0 [NUM_ROWS];
  logic [COL_W-1:0] bank1 [NUM_ROWS];
  logic             front_sel;

  // Write target uses the pre-edge front_sel, so a write in the swap cycle ends up in the new front.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_ROWS); i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
      front_sel <= 1'b0;
    end else begin
      if (wr_en) begin
        if (front_sel) bank0[wr_row] <= wr_data;
        else           bank1[wr_row] <= wr_data;
      end
      if (swap) front_sel <= ~front_sel;
    end
  end

  assign rd_data_c = front_sel ? bank1[rd_row] : bank0[rd_row];

endmodule

// File: rtl/led_row_scan_ctrl.sv
// Row scanner for the 8x8 LED array: blank/show sequencing per row with tear-free buffer swap at frame end.
module led_row_scan_ctrl
  import led_row_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_data,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic [ROW_W-1:0] row_sel,
  output logic [COL_W-1:0] col,
  output logic             blank,
  output logic             frame_st
);

  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_d;
  logic [COL_W-1:0] col_d;
  logic             blank_d;
  logic             frame_st_d;
  logic             swap_now;
  logic             swap_pend_q, swap_pend_d;
  logic [COL_W-1:0] front_col;

  led_frame_dbuf u_dbuf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .swap      (swap_now),
    .rd_row    (row_sel),
    .rd_data_c (front_col)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BLK;
      cnt_q       <= '0;
      row_sel     <= '0;
      col         <= '0;
      blank       <= 1'b1;
      swap_ack    <= 1'b0;
      frame_st    <= 1'b0;
      swap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_sel     <= row_d;
      col         <= col_d;
      blank       <= blank_d;
      swap_ack    <= swap_now;
      frame_st    <= frame_st_d;
      swap_pend_q <= swap_pend_d;
    end
  end

  // Next state plus the output values that accompany it, so outputs move on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    row_d      = row_sel;
    col_d      = '0;
    blank_d    = 1'b1;
    frame_st_d = 1'b0;
    swap_now   = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      row_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = BLK;
          cnt_d      = '0;
          row_d      = '0;
          frame_st_d = 1'b1;
        end
        BLK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
            col_d   = front_col;
            blank_d = 1'b0;
          end
        end
        SHOW: begin
          col_d   = front_col;
          blank_d = 1'b0;
          if (cnt_q == DWELL_LAST) begin
            state_d = BLK;
            cnt_d   = '0;
            row_d   = row_sel + ROW_W'(1);
            col_d   = '0;
            blank_d = 1'b1;
            // Leaving the last row is the only point where the front buffer may change.
            if (row_sel == LAST_ROW) begin
              frame_st_d = 1'b1;
              swap_now   = swap_pend_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          row_d   = '0;
        end
      endcase
    end

    swap_pend_d = (swap_pend_q & ~swap_now) | swap_req;
  end

endmodule
